// File: rtl/program_loader_if.sv
// Load-port and fetch-port bundle between the instruction loader and its host/CPU.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned INST_W = 16
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              loading;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              oeb;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;

    modport master (
        output start, byte_in, byte_valid, oeb, pc,
        input  byte_ready, loading, load_done, word_count, inst
    );

    modport slave (
        input  start, byte_in, byte_valid, oeb, pc,
        output byte_ready, loading, load_done, word_count, inst
    );
endinterface

// File: rtl/program_loader.sv
// Writable instruction store: byte-serial big-endian loader on the write side,
// combinational fetch port gated by oeb and held off while a load is running.
module program_loader #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned INST_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    program_loader_if.slave  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_word_count;
    logic [BYTE_W-1:0]   r_hi;
    logic [INST_W-1:0]   r_mem [DEPTH];
    logic                r_byte_ready;
    logic                r_loading;
    logic                r_load_done;
    logic                w_clear;
    logic                w_latch_hi;
    logic                w_write;
    logic                w_last;

    assign w_last = (r_addr == ADDR_W'(DEPTH - 1));

    // Next-state and datapath strobes; bytes in IDLE/DONE fall through untouched.
    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_latch_hi = 1'b0;
        w_write    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next  = S_HI;
                    w_clear = 1'b1;
                end
            end
            S_HI: begin
                if (bus.byte_valid) begin
                    w_next     = S_LO;
                    w_latch_hi = 1'b1;
                end
            end
            S_LO: begin
                if (bus.byte_valid) begin
                    w_write = 1'b1;
                    w_next  = w_last ? S_DONE : S_HI;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State plus status flags decoded from the next state, so flags track state exactly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_loading    <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == S_HI) || (w_next == S_LO);
            r_loading    <= (w_next == S_HI) || (w_next == S_LO);
            r_load_done  <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_hi         <= '0;
        end else begin
            if (w_clear) begin
                r_addr       <= '0;
                r_word_count <= '0;
            end else if (w_write) begin
                r_word_count <= r_word_count + CNT_W'(1);
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            if (w_latch_hi) begin
                r_hi <= bus.byte_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_addr] <= {r_hi, bus.byte_in};
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.loading    = r_loading;
    assign bus.load_done  = r_load_done;
    assign bus.word_count = r_word_count;
    assign bus.inst       = (bus.oeb && !r_loading) ? r_mem[bus.pc] : '0;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected word counts and
// fetch results, a negedge monitor pops and compares them.
module tb_program_loader;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned INST_W = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    program_loader_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_if ();

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [INST_W-1:0] ref_mem [DEPTH];
    logic [INST_W-1:0] img     [DEPTH];
    bit                ref_loading = 1'b0;
    int                q_wc   [$];
    logic [INST_W-1:0] q_inst [$];
    bit                rd_req = 1'b0;
    logic [ADDR_W:0]   prev_wc = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: word_count steps and requested fetches are checked against the queues.
    always @(negedge clock) begin
        if (u_if.word_count !== prev_wc) begin
            if (u_if.word_count != '0) begin
                if (q_wc.size() == 0) check("word_count_extra", 32'(u_if.word_count), 32'(prev_wc));
                else                  check("word_count", 32'(u_if.word_count), 32'(q_wc.pop_front()));
            end
            prev_wc = u_if.word_count;
        end
        if (rd_req) begin
            if (q_inst.size() == 0) check("inst_no_expect", 32'(u_if.inst), 32'hDEAD);
            else                    check("inst", 32'(u_if.inst), 32'(q_inst.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_byte_ready"}, 32'(u_if.byte_ready), 32'd0);
        check({tag, "_loading"},    32'(u_if.loading),    32'd0);
        check({tag, "_load_done"},  32'(u_if.load_done),  32'd0);
        check({tag, "_word_count"}, 32'(u_if.word_count), 32'd0);
    endtask

    task automatic check_done_outputs();
        check("done_load_done",  32'(u_if.load_done),  32'd1);
        check("done_loading",    32'(u_if.loading),    32'd0);
        check("done_byte_ready", 32'(u_if.byte_ready), 32'd0);
        check("done_word_count", 32'(u_if.word_count), 32'(DEPTH));
    endtask

    task automatic read_check(input int pc, input bit oeb);
        u_if.pc  = ADDR_W'(pc);
        u_if.oeb = oeb;
        q_inst.push_back((oeb && !ref_loading) ? ref_mem[pc] : '0);
        rd_req = 1'b1;
        tick();
        rd_req   = 1'b0;
        u_if.oeb = 1'b0;
    endtask

    task automatic read_all(input bit oeb);
        for (int p = 0; p < DEPTH; p++) read_check(p, oeb);
    endtask

    task automatic apply_reset_midcycle(input string tag);
        u_if.byte_valid = 1'b0;
        u_if.start      = 1'b0;
        #3 reset_n = 1'b0;
        #1 check_idle_outputs(tag);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_loading = 1'b0;
        @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        rdy = 1'b0;
        u_if.byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            check("ready_while_waiting", 32'(u_if.byte_ready), 32'd1);
            tick();
        end
        u_if.byte_in    = b;
        u_if.byte_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            rdy = u_if.byte_ready;
            tick();
            if (rdy) break;
        end
        if (!rdy) check("byte_accept_timeout", 32'd0, 32'd1);
        u_if.byte_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_byte);
        u_if.start = 1'b1;
        if (with_byte) begin
            u_if.byte_valid = 1'b1;
            u_if.byte_in    = 8'hEE;
        end
        tick();
        u_if.start      = 1'b0;
        u_if.byte_valid = 1'b0;
        ref_loading     = 1'b1;
        check("start_loading", 32'(u_if.loading), 32'd1);
    endtask

    // Full load of img[]; optional start pulse while in LO and a fetch attempt mid-load.
    task automatic load_image(input int max_gap, input bit start_with_byte,
                              input int lo_start_at, input bit mid_read, output int edges);
        int t0;
        do_start(start_with_byte);
        t0 = cyc;
        for (int w = 0; w < DEPTH; w++) begin
            send_byte(img[w][15:8], pick_gap(max_gap));
            if (w == lo_start_at) begin
                u_if.start = 1'b1;
                tick();
                u_if.start = 1'b0;
                check("start_in_lo_ignored", 32'(u_if.loading), 32'd1);
            end
            send_byte(img[w][7:0], pick_gap(max_gap));
            ref_mem[w] = img[w];
            q_wc.push_back(w + 1);
            if (mid_read && w == 3) read_check(3, 1'b1);
        end
        edges       = cyc - t0;
        ref_loading = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        u_if.start = 1'b0; u_if.byte_in = '0; u_if.byte_valid = 1'b0;
        u_if.oeb = 1'b0;   u_if.pc = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        #1 check_idle_outputs("por");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();
        read_all(1'b1);

        // Back-to-back pattern load: 0x1001, 0x2002, ... 0x8008
        for (int k = 0; k < DEPTH; k++) img[k] = 16'((k + 1) * 16'h1001);
        load_image(0, 1'b0, -1, 1'b0, edges);
        check("done_edge", 32'(edges), 32'd16);
        check_done_outputs();
        read_all(1'b1);

        // Same image again with throttled valid
        load_image(3, 1'b0, -1, 1'b0, edges);
        check_done_outputs();
        read_all(1'b1);

        // Random image, throttled, start collides with a byte, start pulsed in LO
        for (int k = 0; k < DEPTH; k++) img[k] = 16'($urandom);
        load_image(2, 1'b1, 2, 1'b0, edges);
        check_done_outputs();
        read_all(1'b1);

        // Bytes offered in DONE are dropped
        for (int i = 0; i < 4; i++) begin
            u_if.byte_valid = 1'b1;
            u_if.byte_in    = 8'($urandom);
            @(negedge clock);
            check("done_drop_ready", 32'(u_if.byte_ready), 32'd0);
            tick();
        end
        u_if.byte_valid = 1'b0;
        check_done_outputs();
        read_all(1'b1);

        // Reset after 5 bytes of a new load
        do_start(1'b0);
        for (int b = 0; b < 5; b++) begin
            send_byte(8'($urandom), 0);
            if (b % 2 == 1) q_wc.push_back((b + 1) / 2);
        end
        apply_reset_midcycle("midload_rst");
        read_all(1'b1);
        for (int k = 0; k < DEPTH; k++) img[k] = 16'($urandom);
        load_image(1, 1'b0, -1, 1'b0, edges);
        check_done_outputs();
        read_all(1'b1);

        // Reload from DONE with fetch attempt mid-load, then oeb gating
        for (int k = 0; k < DEPTH; k++) img[k] = 16'($urandom);
        load_image(0, 1'b0, -1, 1'b1, edges);
        check("reload_done_edge", 32'(edges), 32'd17);
        check_done_outputs();
        read_all(1'b1);
        read_all(1'b0);

        repeat (2) tick();
        check("wc_queue_drained",   32'(q_wc.size()),   32'd0);
        check("inst_queue_drained", 32'(q_inst.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
